data_mem_unit: RTL
==================

// Module: data_mem_unit
// PURPOSE
//  Data memory stage that directly consumes the ALU result (ALUout) as a byte address.
//  - Executes MIPS loads/stores: lw, lh, lhu, lb, lbu, sw, sh, sb.
//  - Byte-lane merging on stores; sign/zero extension on loads.
//  - Registered read path, one-cycle latency.
//  - Flags misaligned or out-of-range accesses and suppresses their side effects.
//  - Emits the standard store trace line for the grading harness.
// PARAMETERS
//  DEPTH   3072  number of 32-bit words; valid byte addresses 0 .. DEPTH*4-1
//  ADDR_W  12    word-index width; must satisfy 2**ADDR_W >= DEPTH
// PORTS
//  clk      in   1   rising-edge clock
//  reset_n  in   1   asynchronous, active-low reset
//  pc       in   32  PC of the issuing instruction; used for the trace only
//  req      in   1   access request valid this cycle
//  mem_op   in   3   0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB
//  addr     in   32  byte address (ALU sum of base + offset)
//  wdata    in   32  store data; SH uses [15:0], SB uses [7:0]
//  rdata    out  32  load result, extended to 32 bits
//  rvalid   out  1   one-cycle pulse: load result is on rdata
//  fault    out  1   one-cycle pulse: previous request was misaligned or out of range
// BEHAVIOUR
//  Reset (reset_n low, async)
//  - Immediately: rdata=0, rvalid=0, fault=0.
//  - All DEPTH words are cleared to 0.
//  - req is ignored while reset_n is low.
//  - A load whose result is pending when reset asserts is dropped; no rvalid follows.
//  Fault check (combinational; the result is registered)
//  - Misaligned: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0.
//  - Out of range: addr >= DEPTH*4.
//  - On either condition: no memory write; rvalid=0; rdata=0; fault=1 on the next cycle.
//  - Word index = addr[ADDR_W+1:2]. Byte lane = addr[1:0], little-endian (lane 0 = bits [7:0]).
//  Stores (req=1 at posedge N, no fault)
//  - The memory word is updated at that edge.
//  - SW: whole word is written.
//  - SH: lanes addr[1]*2 .. +1 are written; other lanes unchanged.
//  - SB: lane addr[1:0] is written; other lanes unchanged.
//  - Stores never assert rvalid.
//  - Trace at the same edge: $display("@%h: *%h <= %h", pc, {addr[31:2],2'b00}, merged_word).
//    merged_word is the full 32-bit word after the merge.
//  Loads (req=1 at posedge N, no fault)
//  - Word is read at edge N; rdata and rvalid=1 are valid during cycle N+1.
//  - LH/LB sign-extend. LHU/LBU zero-extend.
//  - rvalid is high for exactly one cycle per load.
//  - rdata holds its value until the next load or fault; it is 0 after a fault.
//  Ordering
//  - Only one op per cycle.
//  - A load issued in the cycle right after a store to the same word returns the post-store data.
//  - Back-to-back loads produce back-to-back rvalid pulses.
//  - When req=0: no write, no trace, rvalid=0, fault=0.
//  - Bits of addr above the range check are not used to alias into memory.
// TESTING
//  1. Reset, then LW 0x0 -> rvalid@N+1, rdata=0x00000000.
//  2. SW 0x10=0x12345678; SB 0x11=0xAB; LW 0x10 -> rdata=0x1234AB78.
//     Trace "@<pc>: *00000010 <= 1234ab78".
//  3. SW 0x20=0x80FF7F01; then:
//     LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080; LH 0x20 -> 0x00007F01;
//     LH 0x22 -> 0xFFFF80FF; LHU 0x22 -> 0x000080FF.
//  4. LW 0x6 and SH 0x3 -> fault pulses, rvalid=0, no trace; memory at 0x4 and 0x0 unchanged.
//     SW at addr DEPTH*4 -> fault.
//  5. SW 0x40=0xDEADBEEF at N; LW 0x40 at N+1 -> rdata=0xDEADBEEF at N+2.
//     Four back-to-back LWs -> four consecutive rvalid pulses.
//  6. Issue LW, then assert reset_n low mid-cycle before the next edge
//     -> rvalid, rdata, fault go to 0 at once; no rvalid after release; LW of a prior store reads 0.

Source files
------------

// File: rtl/data_mem_unit.sv
// Data memory stage: MIPS byte/half/word loads and stores addressed by the ALU result.
// Registered read path; misaligned or out-of-range requests raise a one-cycle fault.
module data_mem_unit #(
  parameter int unsigned DEPTH  = 3072,
  parameter int unsigned ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc,
  input  logic        req,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        fault
);

  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] widx_c;
  logic [1:0]        lane_c;
  logic              is_store_c;
  logic              misalign_c;
  logic              bad_c;
  logic              we_c;
  logic [31:0]       cur_word_c;
  logic [31:0]       merged_c;
  logic [7:0]        byte_sel_c;
  logic [15:0]       half_sel_c;
  logic [31:0]       load_ext_c;
  logic [31:0]       rdata_d;
  logic              rvalid_d;
  logic              fault_d;

  // Address decode, fault check, store merge and load extension
  always_comb begin
    widx_c     = addr[ADDR_W+1:2];
    lane_c     = addr[1:0];
    is_store_c = (mem_op == OP_SW) || (mem_op == OP_SH) || (mem_op == OP_SB);
    misalign_c = 1'b0;
    cur_word_c = mem[widx_c];
    merged_c   = cur_word_c;
    byte_sel_c = cur_word_c[{lane_c, 3'b000} +: 8];
    half_sel_c = cur_word_c[{addr[1], 4'b0000} +: 16];
    load_ext_c = cur_word_c;

    case (mem_op)
      OP_LW, OP_SW:         misalign_c = (lane_c != 2'b00);
      OP_LH, OP_LHU, OP_SH: misalign_c = addr[0];
      default:              misalign_c = 1'b0;
    endcase

    // Upper address bits participate only here, so they can never alias into memory
    bad_c = misalign_c || (addr >= BYTE_LIMIT);
    we_c  = req && is_store_c && !bad_c;

    case (mem_op)
      OP_SW:   merged_c = wdata;
      OP_SH:   merged_c[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      OP_SB:   merged_c[{lane_c, 3'b000} +: 8]    = wdata[7:0];
      default: merged_c = cur_word_c;
    endcase

    case (mem_op)
      OP_LH:   load_ext_c = {{16{half_sel_c[15]}}, half_sel_c};
      OP_LHU:  load_ext_c = {16'h0000, half_sel_c};
      OP_LB:   load_ext_c = {{24{byte_sel_c[7]}}, byte_sel_c};
      OP_LBU:  load_ext_c = {24'h000000, byte_sel_c};
      default: load_ext_c = cur_word_c;
    endcase

    rvalid_d = req && !is_store_c && !bad_c;
    fault_d  = req && bad_c;
    rdata_d  = rdata;
    if (fault_d) begin
      rdata_d = 32'h0000_0000;
    end else if (rvalid_d) begin
      rdata_d = load_ext_c;
    end
  end

  // Storage array; reset clears every word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= 32'h0000_0000;
      end
    end else if (we_c) begin
      mem[widx_c] <= merged_c;
    end
  end

  // Registered load result and status pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata  <= 32'h0000_0000;
      rvalid <= 1'b0;
      fault  <= 1'b0;
    end else begin
      rdata  <= rdata_d;
      rvalid <= rvalid_d;
      fault  <= fault_d;
    end
  end

  // Store trace consumed by the grading harness
  always_ff @(posedge clk) begin
    if (reset_n && we_c) begin
      $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged_c);
    end
  end

endmodule
